// File: rtl/fpu_req_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_req_sequencer
//   Issue/retire stage in front of the floating-point arithmetic units.
//   It takes one IEEE-754 double operation per request handshake and latches
//   the operands and mode. It then holds unit_enable high until the unit
//   reports done, captures the 64-bit result, and presents it on a response
//   port. A cycle watchdog and an illegal-mode check make sure a hung or
//   misused unit always produces a response.
//
//   Handshakes: a transfer happens on a rising clock edge where valid and
//   ready are both 1. A valid, once raised, stays high with its payload
//   stable until that transfer. Ready may depend on state but never on
//   valid.
//
//   Optional feature (macro FPU_SEQ_SKID_EN):
//     Adds a one-entry request skid buffer so that a request can be accepted
//     while an operation is in flight. That request launches in the IDLE
//     cycle that follows the response handshake.
//
// Parameters
//   TIMEOUT : maximum cycles with unit_enable high (2 .. 2**CNT_W-1)
//   CNT_W   : width of the run-cycle counter
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_op1/req_op2         IEEE double operands
//   req_mode                0 add, 1 sub, 2 mul, 3 div, 4 sin_cos, 5-7 illegal
//   unit_enable             enable to the arithmetic unit (registered)
//   unit_op1/op2/mode       latched operands and mode for the unit
//   unit_result/unit_done   unit completion; result valid while done=1
//   rsp_valid/rsp_ready     response handshake
//   rsp_result/rsp_status   result; status 00 ok, 01 timeout, 10 illegal
//   busy                    FSM not in IDLE
//   dbg_state               current FSM state, for checkers
// ---------------------------------------------------------------------------
module fpu_req_sequencer #(
    parameter int TIMEOUT = 128,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_op1,
    input  logic [63:0] req_op2,
    input  logic [2:0]  req_mode,
    output logic        unit_enable,
    output logic [63:0] unit_op1,
    output logic [63:0] unit_op2,
    output logic [2:0]  unit_mode,
    input  logic [63:0] unit_result,
    input  logic        unit_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic [1:0]  rsp_status,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    // Request source seen by the IDLE state: either the port or the skid.
    logic        req_fire;
    logic        sel_valid;
    logic [63:0] sel_op1, sel_op2;
    logic [2:0]  sel_mode;

    logic launch, cap_done, cap_tmo, cap_ill;

`ifdef FPU_SEQ_SKID_EN
    logic        skid_full_q;
    logic [63:0] skid_op1_q, skid_op2_q;
    logic [2:0]  skid_mode_q;

    assign req_ready = !skid_full_q;
    assign req_fire  = req_valid && req_ready;

    // A full skid has priority. While the skid is full, req_ready is 0, so
    // the port cannot fire in the same cycle.
    always_comb begin
        sel_valid = (state_q == IDLE) && (skid_full_q || req_fire);
        sel_op1   = skid_full_q ? skid_op1_q  : req_op1;
        sel_op2   = skid_full_q ? skid_op2_q  : req_op2;
        sel_mode  = skid_full_q ? skid_mode_q : req_mode;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full_q <= 1'b0;
            skid_op1_q  <= '0;
            skid_op2_q  <= '0;
            skid_mode_q <= '0;
        end else if (req_fire && (state_q != IDLE)) begin
            skid_full_q <= 1'b1;
            skid_op1_q  <= req_op1;
            skid_op2_q  <= req_op2;
            skid_mode_q <= req_mode;
        end else if ((state_q == IDLE) && skid_full_q) begin
            skid_full_q <= 1'b0;
        end
    end
`else
    assign req_ready = (state_q == IDLE);
    assign req_fire  = req_valid && req_ready;

    always_comb begin
        sel_valid = req_fire;
        sel_op1   = req_op1;
        sel_op2   = req_op2;
        sel_mode  = req_mode;
    end
`endif

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus one-hot capture strobes for the datapath register.
    // If done and timeout happen in the same cycle, done wins.
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        cap_done = 1'b0;
        cap_tmo  = 1'b0;
        cap_ill  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    if (sel_mode > 3'd4) begin
                        cap_ill = 1'b1;
                        state_d = HOLD;
                    end else begin
                        launch  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (unit_done) begin
                    cap_done = 1'b1;
                    state_d  = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    cap_tmo = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Enable and response-valid are registered copies of the next state.
    // As a result, enable is high for exactly the RUN cycles, and the
    // response appears the cycle after the capture strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_enable <= 1'b0;
            rsp_valid   <= 1'b0;
            unit_op1    <= '0;
            unit_op2    <= '0;
            unit_mode   <= '0;
            cnt_q       <= '0;
            rsp_result  <= '0;
            rsp_status  <= 2'b00;
        end else begin
            unit_enable <= (state_d == RUN);
            rsp_valid   <= (state_d == HOLD);
            if (launch) begin
                unit_op1  <= sel_op1;
                unit_op2  <= sel_op2;
                unit_mode <= sel_mode;
                cnt_q     <= '0;
            end else if ((state_q == RUN) && (cnt_q != CNT_LAST)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cap_done) begin
                rsp_result <= unit_result;
                rsp_status <= 2'b00;
            end else if (cap_tmo) begin
                rsp_result <= '1;
                rsp_status <= 2'b01;
            end else if (cap_ill) begin
                rsp_result <= '1;
                rsp_status <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Testbench for fpu_req_sequencer. There are two instances: dut 0 uses the
// default TIMEOUT and dut 1 uses TIMEOUT=16. A behavioural unit model
// computes real arithmetic. Expected responses come from the rules of the
// sequencer and are kept in an expected queue.
module tb_fpu_req_sequencer;

  localparam int TO0 = 128;
  localparam int TO1 = 16;
  localparam int W = 205;  // {en[7:0], mode[2:0], op1, op2, status[1:0], result}
`ifdef FPU_SEQ_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [63:0] req_op1 [2];
  logic [63:0] req_op2 [2];
  logic [2:0]  req_mode [2];
  logic        unit_enable [2];
  logic [63:0] unit_op1 [2];
  logic [63:0] unit_op2 [2];
  logic [2:0]  unit_mode [2];
  logic [63:0] unit_result [2];
  logic        unit_done [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [63:0] rsp_result [2];
  logic [1:0]  rsp_status [2];
  logic        busy [2];
  logic [1:0]  dbg_state [2];

  int done_cyc [2];
  bit spurious [2];
  int run_cnt [2];

  logic [W-1:0] exp_q[$];
  int n_chk;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  fpu_req_sequencer #(.TIMEOUT(TO0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op1(req_op1[0]), .req_op2(req_op2[0]), .req_mode(req_mode[0]),
    .unit_enable(unit_enable[0]), .unit_op1(unit_op1[0]), .unit_op2(unit_op2[0]),
    .unit_mode(unit_mode[0]), .unit_result(unit_result[0]), .unit_done(unit_done[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_result(rsp_result[0]), .rsp_status(rsp_status[0]),
    .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  fpu_req_sequencer #(.TIMEOUT(TO1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op1(req_op1[1]), .req_op2(req_op2[1]), .req_mode(req_mode[1]),
    .unit_enable(unit_enable[1]), .unit_op1(unit_op1[1]), .unit_op2(unit_op2[1]),
    .unit_mode(unit_mode[1]), .unit_result(unit_result[1]), .unit_done(unit_done[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_result(rsp_result[1]), .rsp_status(rsp_status[1]),
    .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- unit arithmetic and reference model ----------------
  function automatic logic [63:0] unit_fn(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] mode);
    real x;
    real y;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    case (mode)
      3'd0:    return $realtobits(x + y);
      3'd1:    return $realtobits(x - y);
      3'd2:    return $realtobits(x * y);
      3'd3:    return $realtobits(x / y);
      default: return a;
    endcase
  endfunction

  // The expected outcome of one operation. Illegal modes never enable the
  // unit. Otherwise the unit finishes on enable cycle dc (0 = never), unless
  // the watchdog expires first after TIMEOUT enable cycles.
  function automatic logic [W-1:0] model(input int to, input logic [2:0] mode,
                                         input logic [63:0] a, input logic [63:0] b,
                                         input int dc);
    logic [7:0]  en;
    logic [1:0]  st;
    logic [63:0] res;
    if (mode > 3'd4) begin
      en = 8'd0; st = 2'b10; res = '1;
    end else if (dc >= 1 && dc <= to) begin
      en = 8'(dc); st = 2'b00; res = unit_fn(a, b, mode);
    end else begin
      en = 8'(to); st = 2'b01; res = '1;
    end
    return {en, mode, a, b, st, res};
  endfunction

  // Behavioural unit. It counts enable-high cycles and raises done on cycle
  // done_cyc. While disabled it may raise a spurious done with a junk result.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (unit_enable[g]) run_cnt[g] = run_cnt[g] + 1;
      else run_cnt[g] = 0;
      if (unit_enable[g] && run_cnt[g] == done_cyc[g]) begin
        unit_done[g] = 1'b1;
        unit_result[g] = unit_fn(unit_op1[g], unit_op2[g], unit_mode[g]);
      end else if (!unit_enable[g] && spurious[g]) begin
        unit_done[g] = 1'b1;
        unit_result[g] = 64'h0BAD_0BAD_0BAD_0BAD;
      end else begin
        unit_done[g] = 1'b0;
        unit_result[g] = 64'h5A5A_5A5A_5A5A_5A5A;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present one request in IDLE and return right after the accept edge.
  task automatic issue(input int idx, input logic [2:0] mode, input logic [63:0] a,
                       input logic [63:0] b, input int dc);
    @(negedge clk);
    done_cyc[idx] = dc;
    req_valid[idx] = 1'b1;
    req_op1[idx] = a;
    req_op2[idx] = b;
    req_mode[idx] = mode;
    chk("req_ready_idle", 64'(req_ready[idx]), 64'd1);
    exp_q.push_back(model(idx == 0 ? TO0 : TO1, mode, a, b, dc));
    @(posedge clk);
  endtask

  // Follow one operation from the accept edge to the response handshake.
  // c0/en0 allow the caller to have consumed cycles already; sf is the
  // expected skid occupancy while this operation retires.
  task automatic collect(input int idx, input int c0, input int en0, input bit sf,
                         input int hold);
    logic [W-1:0] e;
    int en;
    bit got;
    logic hold_rdy;
    logic idle_rdy;
    hold_rdy = SKID ? !sf : 1'b0;
    idle_rdy = SKID ? !sf : 1'b1;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    en = en0;
    got = 1'b0;
    for (int c = c0; c < 400 && !got; c++) begin
      @(negedge clk);
      req_valid[idx] = 1'b0;
      if (rsp_valid[idx]) begin
        got = 1'b1;
        chk("rsp_latency", 64'(c), 64'(e[204:197]) + 64'd1);
      end else if (unit_enable[idx]) begin
        en++;
        chk("unit_op1", unit_op1[idx], e[193:130]);
        chk("unit_op2", unit_op2[idx], e[129:66]);
        chk("unit_mode", 64'(unit_mode[idx]), 64'(e[196:194]));
        chk("run_busy", 64'(busy[idx]), 64'd1);
        chk("run_req_ready", 64'(req_ready[idx]), 64'(hold_rdy));
      end
    end
    if (!got) chk("rsp_wait_expired", 64'd0, 64'd1);
    chk("enable_cycles", 64'(en), 64'(e[204:197]));
    chk("rsp_result", rsp_result[idx], e[63:0]);
    chk("rsp_status", 64'(rsp_status[idx]), 64'(e[65:64]));
    for (int h = 0; h < hold; h++) begin
      rsp_ready[idx] = 1'b0;
      spurious[idx] = 1'b1;
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid[idx]), 64'd1);
      chk("hold_result", rsp_result[idx], e[63:0]);
      chk("hold_status", 64'(rsp_status[idx]), 64'(e[65:64]));
      chk("hold_enable", 64'(unit_enable[idx]), 64'd0);
      chk("hold_req_ready", 64'(req_ready[idx]), 64'(hold_rdy));
    end
    spurious[idx] = 1'b0;
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
    chk("post_rsp_valid", 64'(rsp_valid[idx]), 64'd0);
    chk("post_busy", 64'(busy[idx]), 64'd0);
    chk("post_enable", 64'(unit_enable[idx]), 64'd0);
    chk("post_req_ready", 64'(req_ready[idx]), 64'(idle_rdy));
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_enable"}, 64'(unit_enable[i]), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid[i]), 64'd0);
      chk({tag, "_rsp_result"}, rsp_result[i], 64'd0);
      chk({tag, "_rsp_status"}, 64'(rsp_status[i]), 64'd0);
      chk({tag, "_busy"}, 64'(busy[i]), 64'd0);
      chk({tag, "_req_ready"}, 64'(req_ready[i]), 64'd1);
      chk({tag, "_unit_op1"}, unit_op1[i], 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] vals [6];

  initial begin
    vals[0] = 64'h3FF0000000000000;  // 1.0
    vals[1] = 64'h4000000000000000;  // 2.0
    vals[2] = 64'h3FE0000000000000;  // 0.5
    vals[3] = 64'h3FF8000000000000;  // 1.5
    vals[4] = 64'h4008000000000000;  // 3.0
    vals[5] = 64'hC000000000000000;  // -2.0
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_op1[i] = '0; req_op2[i] = '0; req_mode[i] = '0;
      rsp_ready[i] = 1'b0; done_cyc[i] = 0; spurious[i] = 1'b0; run_cnt[i] = 0;
      unit_done[i] = 1'b0; unit_result[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    // Divide 1.5 / 0.5; the unit finishes on enable cycle 60; hold for 10 cycles.
    issue(0, 3'd3, 64'h3FF8000000000000, 64'h3FE0000000000000, 60);
    collect(0, 1, 0, 1'b0, 10);

    // Watchdog expiry on the TIMEOUT=16 instance.
    issue(1, 3'd0, vals[0], vals[1], 0);
    collect(1, 1, 0, 1'b0, 2);

    // Illegal mode 110.
    issue(0, 3'b110, vals[0], vals[1], 5);
    collect(0, 1, 0, 1'b0, 1);

    // Done arrives in the same cycle the counter reaches TIMEOUT-1: done wins.
    issue(1, 3'd0, vals[0], vals[0], TO1);
    collect(1, 1, 0, 1'b0, 0);

    // Reset during RUN: enable and response drop at once, nothing is retired.
    issue(0, 3'd2, vals[1], vals[4], 0);
    repeat (5) @(negedge clk);
    req_valid[0] = 1'b0;
    chk("pre_rst_enable", 64'(unit_enable[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_enable", 64'(unit_enable[0]), 64'd0);
    chk("async_rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("async_rst_busy", 64'(busy[0]), 64'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    issue(0, 3'd1, vals[4], vals[0], 3);
    collect(0, 1, 0, 1'b0, 1);

`ifdef FPU_SEQ_SKID_EN
    // A second request, issued while the first is running, goes to the skid.
    issue(0, 3'd3, 64'h3FF8000000000000, 64'h3FE0000000000000, 10);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_op1[0] = 64'h3FF0000000000000;
    req_op2[0] = 64'h3FF0000000000000;
    req_mode[0] = 3'd0;
    chk("skid_accept_ready", 64'(req_ready[0]), 64'd1);
    chk("skid_first_enable", 64'(unit_enable[0]), 64'd1);
    exp_q.push_back(model(TO0, 3'd0, 64'h3FF0000000000000, 64'h3FF0000000000000, 10));
    @(posedge clk);
    collect(0, 2, 1, 1'b1, 2);
    @(posedge clk);
    collect(0, 1, 0, 1'b0, 1);
`endif

    // Randomized operations across both instances.
    for (int t = 0; t < 24; t++) begin
      int idx;
      int to;
      int dc;
      logic [2:0] mode;
      idx = int'($urandom_range(0, 1));
      to = (idx == 0) ? TO0 : TO1;
      mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) dc = 0;
      else dc = int'($urandom_range(1, to + 2));
      issue(idx, mode, vals[$urandom_range(0, 5)], vals[$urandom_range(0, 5)], dc);
      collect(idx, 1, 0, 1'b0, int'($urandom_range(0, 3)));
    end

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
